amat_monitor: RTL

Downstream consumer of the cache hierarchy's per-access outcome strobes (`hit_l1`, `miss_l1`, `hit_l2`, `miss_l2`). Keeps cumulative hit/miss counters and measures average memory access time (AMAT) over fixed windows of accesses. Each window's AMAT is computed by a sequential divider and reported in unsigned fixed point. Sits beside `top`'s cache stack and replaces ad-hoc simulation-only metric printing with synthesizable hardware.

---
 rtl/amat_monitor.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/amat_monitor.sv
`default_nettype none
// ============================================================================
// Module   : amat_monitor
// Desc     : Cumulative L1/L2 hit/miss counters plus windowed average memory
//            access time (AMAT). Each window's AMAT is computed by a 32-step
//            restoring divider and reported in unsigned fixed point.
// Config   : AMAT_MONITOR_SATURATE_EN - cumulative counters saturate at
//            0xFFFFFFFF instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module amat_monitor #(
  parameter int WINDOW    = 64,
  parameter int L1_LAT    = 1,
  parameter int L2_LAT    = 10,
  parameter int MEM_LAT   = 100,
  parameter int FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        hit_l1,
  input  logic        miss_l1,
  input  logic        hit_l2,
  input  logic        miss_l2,
  output logic [31:0] l1_hits,
  output logic [31:0] l1_misses,
  output logic [31:0] l2_hits,
  output logic [31:0] l2_misses,
  output logic [23:0] amat_q,
  output logic        amat_valid,
  output logic        busy,
  output logic        overrun,
  output logic        protocol_err
);

  localparam logic [15:0] C_WIN      = 16'(WINDOW);
  // The window always closes with exactly WINDOW accesses, so the L1 share
  // of the total is a constant.
  localparam logic [31:0] C_BASE_LAT = 32'(WINDOW * L1_LAT);
  localparam logic [31:0] C_L2_LAT   = 32'(L2_LAT);
  localparam logic [31:0] C_MEM_LAT  = 32'(MEM_LAT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic        acc_l1_hit, acc_l2_hit, acc_mem, acc_any, strobe_any, illegal;
  logic        win_close;
  logic [15:0] win_acc_q, win_acc_d, win_l1m_q, win_l1m_d, win_l2m_q, win_l2m_d;
  logic [15:0] win_acc_inc, win_l1m_inc, win_l2m_inc;
  logic [31:0] total, dividend;
  logic [31:0] l1_hits_q, l1_hits_d, l1_misses_q, l1_misses_d;
  logic [31:0] l2_hits_q, l2_hits_d, l2_misses_q, l2_misses_d;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [15:0] rem_q, rem_d, rem_sub;
  logic [16:0] rem_shift;
  logic        rem_ge;
  logic [23:0] amat_d;
  logic        amat_valid_q, amat_valid_d, overrun_q, overrun_d, perr_q, perr_d;

  function automatic logic [31:0] cnt_inc(input logic [31:0] v, input logic en);
`ifdef AMAT_MONITOR_SATURATE_EN
    cnt_inc = (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
`else
    cnt_inc = v + {31'd0, en};
`endif
  endfunction

  // Decode the strobe combination into exactly one legal access type.
  always_comb begin
    acc_l1_hit = hit_l1 & ~miss_l1 & ~hit_l2 & ~miss_l2;
    acc_l2_hit = ~hit_l1 & miss_l1 & hit_l2 & ~miss_l2;
    acc_mem    = ~hit_l1 & miss_l1 & ~hit_l2 & miss_l2;
    acc_any    = acc_l1_hit | acc_l2_hit | acc_mem;
    strobe_any = hit_l1 | miss_l1 | hit_l2 | miss_l2;
    illegal    = strobe_any & ~acc_any;
  end

  // Counter and window next-state, plus the closing-window latency total.
  always_comb begin
    l1_hits_d   = cnt_inc(l1_hits_q, acc_l1_hit);
    l1_misses_d = cnt_inc(l1_misses_q, acc_l2_hit | acc_mem);
    l2_hits_d   = cnt_inc(l2_hits_q, acc_l2_hit);
    l2_misses_d = cnt_inc(l2_misses_q, acc_mem);
    win_acc_inc = win_acc_q + 16'd1;
    win_l1m_inc = win_l1m_q + {15'd0, acc_l2_hit | acc_mem};
    win_l2m_inc = win_l2m_q + {15'd0, acc_mem};
    win_close   = acc_any && (win_acc_inc == C_WIN);
    total       = C_BASE_LAT + ({16'd0, win_l1m_inc} * C_L2_LAT)
                             + ({16'd0, win_l2m_inc} * C_MEM_LAT);
    dividend    = total << FRAC_BITS;
    win_acc_d   = win_acc_q;
    win_l1m_d   = win_l1m_q;
    win_l2m_d   = win_l2m_q;
    if (acc_any) begin
      win_acc_d = win_close ? 16'd0 : win_acc_inc;
      win_l1m_d = win_close ? 16'd0 : win_l1m_inc;
      win_l2m_d = win_close ? 16'd0 : win_l2m_inc;
    end
  end

  // Divider FSM: load on window close, 32 restoring steps, publish result.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    amat_d       = amat_q;
    amat_valid_d = 1'b0;
    rem_shift    = {rem_q, quo_q[31]};
    rem_ge       = rem_shift >= {1'b0, C_WIN};
    // When rem_ge holds the difference is below WINDOW, so 16 bits suffice.
    rem_sub      = rem_shift[15:0] - C_WIN;
    overrun_d    = overrun_q | (win_close && (state_q != ST_IDLE));
    perr_d       = perr_q | illegal;
    case (state_q)
      ST_IDLE: begin
        if (win_close) begin
          state_d = ST_DIV;
          quo_d   = dividend;
          rem_d   = 16'd0;
          cnt_d   = 5'd0;
        end
      end
      ST_DIV: begin
        quo_d = {quo_q[30:0], rem_ge};
        rem_d = rem_ge ? rem_sub : rem_shift[15:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        amat_d       = quo_q[23:0];
        amat_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; clear has priority over any same-cycle access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      l1_hits_q    <= 32'd0;
      l1_misses_q  <= 32'd0;
      l2_hits_q    <= 32'd0;
      l2_misses_q  <= 32'd0;
      win_acc_q    <= 16'd0;
      win_l1m_q    <= 16'd0;
      win_l2m_q    <= 16'd0;
      state_q      <= ST_IDLE;
      cnt_q        <= 5'd0;
      quo_q        <= 32'd0;
      rem_q        <= 16'd0;
      amat_q       <= 24'd0;
      amat_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      l1_hits_q    <= l1_hits_d;
      l1_misses_q  <= l1_misses_d;
      l2_hits_q    <= l2_hits_d;
      l2_misses_q  <= l2_misses_d;
      win_acc_q    <= win_acc_d;
      win_l1m_q    <= win_l1m_d;
      win_l2m_q    <= win_l2m_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      amat_q       <= amat_d;
      amat_valid_q <= amat_valid_d;
      overrun_q    <= overrun_d;
      perr_q       <= perr_d;
    end
  end

  assign l1_hits      = l1_hits_q;
  assign l1_misses    = l1_misses_q;
  assign l2_hits      = l2_hits_q;
  assign l2_misses    = l2_misses_q;
  assign amat_valid   = amat_valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign overrun      = overrun_q;
  assign protocol_err = perr_q;

endmodule
`default_nettype wire
